// File: rtl/if_id_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_buffer_pkg
// Description : Shared fetch-to-decode types and constants.
// Revision    : 1.0 - initial release
// ============================================================================
package if_id_buffer_pkg;

  localparam int XLEN = 32;

  // Decode substitutes this when the buffer is empty.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
    logic [XLEN-1:0] instr;
  } if_id_t;

endpackage
`default_nettype wire

// File: rtl/if_id_fifo.sv
`default_nettype none
// ============================================================================
// Module      : if_id_fifo
// Description : DEPTH-entry synchronous FIFO of if_id_t with flush; head is a
//               combinational read of the register array.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_fifo
  import if_id_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  if_id_t                     push_data,
  input  logic                       pop,
  output if_id_t                     head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  if_id_t        r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_push = push & ~flush;
  assign w_do_pop  = pop & (r_count != '0);

  // Pointers are power-of-two wide and wrap on their own; full/empty come only from count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

`ifndef SYNTHESIS
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    w_do_push |-> (r_count != CW'(DEPTH)));
`endif

endmodule
`default_nettype wire

// File: rtl/if_id_buffer.sv
`default_nettype none
// ============================================================================
// Module      : if_id_buffer
// Description : IF->ID buffer: aligns PC with the BRAM instruction, queues and
//               hands entries to decode. IF_ID_BUF_BYPASS_EN enables the
//               empty-path bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fetch_valid,
  input  logic [XLEN-1:0]            fetch_pc,
  input  logic [XLEN-1:0]            fetch_pcplus4,
  input  logic [XLEN-1:0]            bram_instr,
  input  logic                       flush,
  output logic                       fetch_en,
  output if_id_t                     out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);

  logic            r_p_valid;
  logic [XLEN-1:0] r_p_pc;
  logic [XLEN-1:0] r_p_pcplus4;
  if_id_t          w_entry;
  if_id_t          w_head;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_occupancy;
  logic            w_fifo_valid;
  logic            w_bypass;
  logic            w_push;
  logic            w_pop;

  // The BRAM answers one cycle after the fetch, so the PC is held for a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_valid   <= 1'b0;
      r_p_pc      <= '0;
      r_p_pcplus4 <= '0;
    end else begin
      r_p_valid <= fetch_valid & ~flush;
      if (fetch_valid) begin
        r_p_pc      <= fetch_pc;
        r_p_pcplus4 <= fetch_pcplus4;
      end
    end
  end

  assign w_entry      = {r_p_pc, r_p_pcplus4, bram_instr};
  assign w_fifo_valid = (w_count != '0);

`ifdef IF_ID_BUF_BYPASS_EN
  assign w_bypass = ~w_fifo_valid & r_p_valid & ~flush;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed entry that decode takes immediately never occupies a slot.
  assign w_push = r_p_valid & ~flush & ~(w_bypass & out_ready);
  assign w_pop  = w_fifo_valid & out_ready;

  if_id_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push     (w_push),
    .push_data(w_entry),
    .pop      (w_pop),
    .head     (w_head),
    .count    (w_count)
  );

  always_comb begin
    out = '0;
    if (w_fifo_valid) out = w_head;
    else if (w_bypass) out = w_entry;
  end

  assign out_valid = w_fifo_valid | w_bypass;
  assign count     = w_count;

  // Reserve a slot for the in-flight entry; a same-cycle dequeue is not credited.
  assign w_occupancy = {1'b0, w_count} + {{CW{1'b0}}, r_p_valid};
  assign fetch_en    = (w_occupancy < (CW+1)'(DEPTH));

`ifndef SYNTHESIS
  a_fetch_when_stalled : assert property (@(posedge clk) disable iff (!rst_n)
    fetch_valid |-> fetch_en);
`endif

endmodule
`default_nettype wire
